// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_pkg
//  Description : Shared definitions for the PS/2 host interface: transmitter
//                state encoding, keyboard command bytes, the keyboard ack
//                byte, the idle line level and the frame bit-counter limit.
//  Revision    : 1.0  initial release
// ============================================================================
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INHIBIT = 3'd1,
        ST_RTS     = 3'd2,
        ST_SHIFT   = 3'd3,
        ST_ACK     = 3'd4,
        ST_RELEASE = 3'd5
    } ps2_state_t;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] ACK_BYTE     = 8'hFA;

    // Released open-drain lines float high through the bus pull-ups.
    localparam logic       LINE_IDLE    = 1'b1;

    // 11 device clock falling edges make up one host-to-device frame.
    localparam logic [3:0] BIT_CNT_MAX  = 4'd11;

endpackage : ps2_pkg
`default_nettype wire

// File: rtl/ps2_line_filter.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_line_filter
//  Description : Brings one asynchronous PS/2 line into the clk domain through
//                a 2-flop synchroniser, then only accepts a new level once the
//                synchronised line has held it for FILTER_CYCLES clk cycles.
//  Ports       : clk      - system clock
//                rst_n    - asynchronous active-low reset (filter preset to 1)
//                line_in  - raw PS/2 line (clock or data)
//                line_out - synchronised, de-glitched line level
//  Revision    : 1.0  initial release
// ============================================================================
module ps2_line_filter
    import ps2_pkg::*;
#(
    parameter int FILTER_CYCLES = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line_in,
    output logic line_out
);

    localparam int                 c_CNT_W    = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(FILTER_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    logic [1:0]         r_sync;
    logic               r_filt;
    logic [c_CNT_W-1:0] r_cnt;

    // r_cnt counts consecutive cycles the synchronised line disagrees with
    // the accepted level; any agreement restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {2{LINE_IDLE}};
            r_filt <= LINE_IDLE;
            r_cnt  <= '0;
        end else begin
            r_sync <= {r_sync[0], line_in};
            if (r_sync[1] == r_filt) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_LAST) begin
                r_filt <= r_sync[1];
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end
        end
    end

    assign line_out = r_filt;

endmodule : ps2_line_filter
`default_nettype wire

// File: rtl/ps2_transmitter.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_transmitter
//  Description : PS/2 host-to-device byte transmitter. Inhibits the bus,
//                issues request-to-send, shifts data/odd parity/stop on the
//                device clock falling edges, checks the device ack and
//                reports tx_done or tx_err. Only open-drain pull-low controls
//                reach the bus.
//  Ports       : clk, rst_n            - clock, async active-low reset
//                tx_data/valid/ready   - byte request handshake
//                ps2_clk_in/data_in    - sensed bus lines (asynchronous)
//                ps2_*_drive_low       - 1 pulls the line low, 0 releases it
//                busy                  - frame in progress
//                tx_done / tx_err      - one-cycle completion / failure pulses
//  Revision    : 1.0  initial release
// ============================================================================
module ps2_transmitter
    import ps2_pkg::*;
#(
    parameter int CLK_HZ         = 100_000_000,
    parameter int INHIBIT_CYCLES = 12_000,
    parameter int TIMEOUT_CYCLES = 1_500_000,
    parameter int FILTER_CYCLES  = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_drive_low,
    output logic       ps2_data_drive_low,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err
);

    localparam int c_TIMER_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
    localparam int c_TIMER_W   = $clog2(c_TIMER_MAX + 1);
    localparam logic [c_TIMER_W-1:0] c_TIMEOUT_LAST = c_TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_TIMER_W-1:0] c_INHIBIT_LAST = c_TIMER_W'(INHIBIT_CYCLES - 1);
    localparam logic [c_TIMER_W-1:0] c_TIMER_ONE    = c_TIMER_W'(1);

    logic w_clk_filt;
    logic w_data_filt;
    logic w_timed;
    logic w_abort;
    logic w_unused_cfg;

    ps2_state_t           r_state;
    logic [7:0]           r_data;
    logic                 r_parity;
    logic [3:0]           r_bit_cnt;
    logic [c_TIMER_W-1:0] r_timer;
    logic                 r_clk_prev;
    logic                 r_fall;
    logic                 r_ack_ok;
    logic                 r_clk_drv;
    logic                 r_data_drv;
    logic                 r_ready;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_err;

    // Clock frequency is informational; all timing is given in clk cycles.
    assign w_unused_cfg = (CLK_HZ > 0);

    ps2_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_clk_filter (
        .clk      (clk),
        .rst_n    (rst_n),
        .line_in  (ps2_clk_in),
        .line_out (w_clk_filt)
    );

    ps2_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_data_filter (
        .clk      (clk),
        .rst_n    (rst_n),
        .line_in  (ps2_data_in),
        .line_out (w_data_filt)
    );

    // The device must keep clocking while we wait on it; a falling edge in
    // the same cycle as the last timer count still counts as progress.
    assign w_timed = (r_state == ST_RTS) || (r_state == ST_SHIFT) || (r_state == ST_RELEASE);
    assign w_abort = w_timed && !r_fall && (r_timer == c_TIMEOUT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_data     <= '0;
            r_parity   <= 1'b0;
            r_bit_cnt  <= '0;
            r_timer    <= '0;
            r_clk_prev <= LINE_IDLE;
            r_fall     <= 1'b0;
            r_ack_ok   <= 1'b0;
            r_clk_drv  <= 1'b0;
            r_data_drv <= 1'b0;
            r_ready    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_clk_prev <= w_clk_filt;
            r_fall     <= r_clk_prev & ~w_clk_filt;
            r_done     <= 1'b0;
            r_err      <= 1'b0;

            if (w_timed) begin
                r_timer <= r_fall ? '0 : r_timer + c_TIMER_ONE;
            end

            if (w_abort) begin
                r_clk_drv  <= 1'b0;
                r_data_drv <= 1'b0;
                r_err      <= 1'b1;
                r_timer    <= '0;
                r_ready    <= 1'b1;
                r_busy     <= 1'b0;
                r_state    <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (tx_valid && r_ready) begin
                            r_data     <= tx_data;
                            r_parity   <= ~^tx_data;
                            r_bit_cnt  <= '0;
                            r_timer    <= '0;
                            r_clk_drv  <= 1'b1;
                            r_data_drv <= 1'b0;
                            r_ready    <= 1'b0;
                            r_busy     <= 1'b1;
                            r_state    <= ST_INHIBIT;
                        end else begin
                            r_ready <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end

                    // The timer doubles as the inhibit counter before RTS.
                    ST_INHIBIT: begin
                        if (r_timer == c_INHIBIT_LAST) begin
                            r_timer    <= '0;
                            r_data_drv <= 1'b1;
                            r_state    <= ST_RTS;
                        end else begin
                            r_timer <= r_timer + c_TIMER_ONE;
                        end
                    end

                    ST_RTS: begin
                        r_clk_drv <= 1'b0;
                        r_state   <= ST_SHIFT;
                    end

                    // r_bit_cnt holds the number of falling edges already
                    // seen, so edge n drives data bit r_bit_cnt == n-1.
                    ST_SHIFT: begin
                        if (r_fall) begin
                            if (r_bit_cnt < 4'd8) begin
                                r_data_drv <= ~r_data[r_bit_cnt[2:0]];
                            end else if (r_bit_cnt == 4'd8) begin
                                r_data_drv <= ~r_parity;
                            end else begin
                                r_data_drv <= 1'b0;
                            end
                            if (r_bit_cnt == BIT_CNT_MAX - 4'd1) begin
                                r_state <= ST_ACK;
                            end
                            if (r_bit_cnt != BIT_CNT_MAX) begin
                                r_bit_cnt <= r_bit_cnt + 4'd1;
                            end
                        end
                    end

                    ST_ACK: begin
                        r_ack_ok <= ~w_data_filt;
                        r_err    <= w_data_filt;
                        r_state  <= ST_RELEASE;
                    end

                    ST_RELEASE: begin
                        if (w_clk_filt && w_data_filt) begin
                            r_done  <= r_ack_ok;
                            r_ready <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end

                    default: begin
                        r_clk_drv  <= 1'b0;
                        r_data_drv <= 1'b0;
                        r_busy     <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign tx_ready           = r_ready;
    assign busy               = r_busy;
    assign tx_done            = r_done;
    assign tx_err             = r_err;
    assign ps2_clk_drive_low  = r_clk_drv;
    assign ps2_data_drive_low = r_data_drv;

endmodule : ps2_transmitter
`default_nettype wire

// File: tb/tb_ps2_transmitter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_transmitter
//  Description : Self-checking bench for ps2_transmitter. A keyboard model
//                clocks frames out of the host and captures what appears on
//                the data line; captured frames are compared with a frame
//                built from the byte value (start, LSB-first data, odd
//                parity, stop).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ps2_transmitter;
    import ps2_pkg::*;

    localparam int c_INHIBIT  = 40;
    localparam int c_TIMEOUT  = 600;
    localparam int c_FILTER   = 4;
    localparam int c_HALF     = 20;
    localparam int c_WAIT_MAX = 3000;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_drive_low;
    logic       ps2_data_drive_low;
    logic       busy;
    logic       tx_done;
    logic       tx_err;

    // Device side of the open-drain bus: released lines read high.
    logic dev_clk  = 1'b1;
    logic dev_data = 1'b1;
    assign ps2_clk_in  = dev_clk  & ~ps2_clk_drive_low;
    assign ps2_data_in = dev_data & ~ps2_data_drive_low;

    int checks = 0;
    int errors = 0;
    int n_done = 0;
    int n_err  = 0;
    int n_both = 0;

    ps2_transmitter #(
        .CLK_HZ         (100_000_000),
        .INHIBIT_CYCLES (c_INHIBIT),
        .TIMEOUT_CYCLES (c_TIMEOUT),
        .FILTER_CYCLES  (c_FILTER)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .tx_data            (tx_data),
        .tx_valid           (tx_valid),
        .tx_ready           (tx_ready),
        .ps2_clk_in         (ps2_clk_in),
        .ps2_data_in        (ps2_data_in),
        .ps2_clk_drive_low  (ps2_clk_drive_low),
        .ps2_data_drive_low (ps2_data_drive_low),
        .busy               (busy),
        .tx_done            (tx_done),
        .tx_err             (tx_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tx_done === 1'b1) n_done++;
        if (tx_err === 1'b1) n_err++;
        if (tx_done === 1'b1 && tx_err === 1'b1) n_both++;
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog expired");
    end

    // Expected wire frame {stop, parity, data[7:0], start}: parity makes the
    // total number of ones across data+parity odd.
    function automatic logic [10:0] frame_model(input logic [7:0] b);
        int  ones;
        logic par;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        par = ((ones % 2) == 0) ? 1'b1 : 1'b0;
        return {1'b1, par, b, 1'b0};
    endfunction

    task automatic start_tx(input logic [7:0] b);
        int t;
        t = 0;
        while (tx_ready !== 1'b1 && t < c_WAIT_MAX) begin
            @(negedge clk);
            t++;
        end
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Keyboard model: waits for inhibit and request-to-send, then generates
    // up to max_falls clock pulses, sampling the data line on each rising edge.
    task automatic dev_frame(input bit ack, input int max_falls,
                             output logic [10:0] bits, output bit ok);
        int t;
        ok   = 1'b1;
        bits = '1;
        t = 0;
        while (ps2_clk_drive_low !== 1'b1 && t < c_WAIT_MAX) begin
            @(negedge clk);
            t++;
        end
        t = 0;
        while (ps2_clk_drive_low !== 1'b0 && t < c_WAIT_MAX) begin
            @(negedge clk);
            t++;
        end
        if (ps2_clk_drive_low !== 1'b0) begin
            ok = 1'b0;
            return;
        end
        bits[0] = ps2_data_in;
        repeat (c_HALF) @(negedge clk);
        for (int i = 1; i <= max_falls; i++) begin
            dev_clk = 1'b0;
            repeat (c_HALF) @(negedge clk);
            dev_clk = 1'b1;
            if (i <= 10) bits[i] = ps2_data_in;
            if (i == 10 && ack) dev_data = 1'b0;
            repeat (c_HALF) @(negedge clk);
        end
        dev_data = 1'b1;
    endtask

    task automatic wait_idle(output bit ok);
        int t;
        t = 0;
        while (busy !== 1'b0 && t < c_WAIT_MAX) begin
            @(negedge clk);
            t++;
        end
        ok = (busy === 1'b0);
        repeat (2) @(negedge clk);
    endtask

    task automatic run_frame(input logic [7:0] b, input bit ack,
                             output logic [10:0] frame, output bit ok,
                             output int d_done, output int d_err);
        int d0, e0;
        bit ok1, ok2;
        d0 = n_done;
        e0 = n_err;
        start_tx(b);
        dev_frame(ack, 11, frame, ok1);
        wait_idle(ok2);
        ok     = ok1 & ok2;
        d_done = n_done - d0;
        d_err  = n_err - e0;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        tx_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({ps2_clk_drive_low, ps2_data_drive_low, busy, tx_ready, tx_done, tx_err} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b want 000000",
                     {ps2_clk_drive_low, ps2_data_drive_low, busy, tx_ready, tx_done, tx_err});
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset got %b want 1", tx_ready);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_after_reset got %b want 0", busy);
        end
    endtask

    task automatic test_set_leds();
        logic [10:0] f;
        bit ok;
        int dd, de;
        run_frame(CMD_SET_LEDS, 1'b1, f, ok, dd, de);
        checks++;
        if (!ok || f !== frame_model(CMD_SET_LEDS)) begin
            errors++;
            $display("FAIL set_leds_frame got %b ok=%0d want %b", f, ok, frame_model(CMD_SET_LEDS));
        end
        checks++;
        if (dd !== 1 || de !== 0) begin
            errors++;
            $display("FAIL set_leds_pulses got done=%0d err=%0d want done=1 err=0", dd, de);
        end
        checks++;
        if ({ps2_clk_drive_low, ps2_data_drive_low, tx_ready} !== 3'b001) begin
            errors++;
            $display("FAIL set_leds_idle got %b want 001", {ps2_clk_drive_low, ps2_data_drive_low, tx_ready});
        end
    endtask

    task automatic test_parity();
        logic [10:0] f;
        bit ok;
        int dd, de;
        run_frame(8'h01, 1'b1, f, ok, dd, de);
        checks++;
        if (!ok || f[9] !== 1'b0 || f !== frame_model(8'h01)) begin
            errors++;
            $display("FAIL parity_01 got %b want %b", f, frame_model(8'h01));
        end
        run_frame(8'h00, 1'b1, f, ok, dd, de);
        checks++;
        if (!ok || f[9] !== 1'b1 || f !== frame_model(8'h00)) begin
            errors++;
            $display("FAIL parity_00 got %b want %b", f, frame_model(8'h00));
        end
    endtask

    task automatic test_random();
        logic [10:0] f;
        logic [7:0]  b;
        bit ok;
        int dd, de;
        for (int i = 0; i < 5; i++) begin
            b = (i == 0) ? ACK_BYTE : 8'($urandom);
            run_frame(b, 1'b1, f, ok, dd, de);
            checks++;
            if (!ok || f !== frame_model(b) || dd !== 1 || de !== 0) begin
                errors++;
                $display("FAIL random_frame byte=%h got %b done=%0d err=%0d want %b done=1 err=0",
                         b, f, dd, de, frame_model(b));
            end
        end
    endtask

    task automatic test_no_ack();
        logic [10:0] f;
        bit ok;
        int dd, de;
        run_frame(CMD_ENABLE, 1'b0, f, ok, dd, de);
        checks++;
        if (!ok || f !== frame_model(CMD_ENABLE)) begin
            errors++;
            $display("FAIL no_ack_frame got %b want %b", f, frame_model(CMD_ENABLE));
        end
        checks++;
        if (dd !== 0 || de !== 1) begin
            errors++;
            $display("FAIL no_ack_pulses got done=%0d err=%0d want done=0 err=1", dd, de);
        end
        checks++;
        if ({ps2_clk_drive_low, ps2_data_drive_low, busy} !== 3'b000) begin
            errors++;
            $display("FAIL no_ack_released got %b want 000", {ps2_clk_drive_low, ps2_data_drive_low, busy});
        end
    endtask

    task automatic test_timeout();
        int t, n, d0, e0;
        d0 = n_done;
        e0 = n_err;
        start_tx(CMD_RESET);
        t = 0;
        while (ps2_data_drive_low !== 1'b1 && t < c_WAIT_MAX) begin
            @(negedge clk);
            t++;
        end
        n = 0;
        while (tx_err !== 1'b1 && n < 2 * c_TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != c_TIMEOUT) begin
            errors++;
            $display("FAIL timeout_latency got %0d cycles want %0d", n, c_TIMEOUT);
        end
        checks++;
        if ({ps2_clk_drive_low, ps2_data_drive_low, busy, tx_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL timeout_idle got %b want 0001",
                     {ps2_clk_drive_low, ps2_data_drive_low, busy, tx_ready});
        end
        repeat (3) @(negedge clk);
        checks++;
        if (n_err - e0 !== 1 || n_done - d0 !== 0) begin
            errors++;
            $display("FAIL timeout_pulses got err=%0d done=%0d want err=1 done=0", n_err - e0, n_done - d0);
        end
    endtask

    task automatic test_reset_midframe();
        logic [10:0] f;
        bit ok;
        int dd, de, d0, e0;
        start_tx(8'h00);
        dev_frame(1'b1, 4, f, ok);
        checks++;
        if (!ok || ps2_data_drive_low !== 1'b1) begin
            errors++;
            $display("FAIL midframe_driving got data_drive_low=%b ok=%0d want 1", ps2_data_drive_low, ok);
        end
        d0 = n_done;
        e0 = n_err;
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ps2_clk_drive_low, ps2_data_drive_low, busy} !== 3'b000) begin
            errors++;
            $display("FAIL midframe_async_release got %b want 000",
                     {ps2_clk_drive_low, ps2_data_drive_low, busy});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (n_done !== d0 || n_err !== e0) begin
            errors++;
            $display("FAIL midframe_no_pulse got done=%0d err=%0d want done=0 err=0", n_done - d0, n_err - e0);
        end
        run_frame(CMD_RESET, 1'b1, f, ok, dd, de);
        checks++;
        if (!ok || f !== frame_model(CMD_RESET) || dd !== 1 || de !== 0) begin
            errors++;
            $display("FAIL after_reset_frame got %b done=%0d err=%0d want %b done=1 err=0",
                     f, dd, de, frame_model(CMD_RESET));
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] f1, f2;
        bit ok1, ok2, ok3;
        int t, d0;
        d0 = n_done;
        tx_data  = CMD_ENABLE;
        tx_valid = 1'b1;
        t = 0;
        while (busy !== 1'b1 && t < c_WAIT_MAX) begin
            @(negedge clk);
            t++;
        end
        tx_data = 8'hAA;
        dev_frame(1'b1, 11, f1, ok1);
        t = 0;
        while (n_done == d0 && t < c_WAIT_MAX) begin
            @(negedge clk);
            t++;
        end
        t = 0;
        while (busy !== 1'b1 && t < c_WAIT_MAX) begin
            @(negedge clk);
            t++;
        end
        tx_valid = 1'b0;
        dev_frame(1'b1, 11, f2, ok2);
        wait_idle(ok3);
        checks++;
        if (!ok1 || f1 !== frame_model(CMD_ENABLE)) begin
            errors++;
            $display("FAIL b2b_first got %b want %b", f1, frame_model(CMD_ENABLE));
        end
        checks++;
        if (!ok2 || !ok3 || f2 !== frame_model(8'hAA)) begin
            errors++;
            $display("FAIL b2b_second got %b want %b", f2, frame_model(8'hAA));
        end
        repeat (5) @(negedge clk);
        checks++;
        if (n_done - d0 !== 2 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_count got done=%0d busy=%b want done=2 busy=0", n_done - d0, busy);
        end
    endtask

    task automatic test_exclusive();
        checks++;
        if (n_both !== 0) begin
            errors++;
            $display("FAIL done_err_overlap got %0d cycles want 0", n_both);
        end
    endtask

    initial begin
        test_reset();
        test_set_leds();
        test_parity();
        test_random();
        test_no_ack();
        test_timeout();
        test_reset_midframe();
        test_back_to_back();
        test_exclusive();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_ps2_transmitter
`default_nettype wire

// File: doc/ps2_transmitter.md
PS2_TRANSMITTER -- requirements
Module: ps2_transmitter

Interface
REQ-001 Parameter CLK_HZ, 100_000_000, frequency of clk in Hz.
REQ-002 Parameter INHIBIT_CYCLES, 12_000, clk cycles the PS/2 clock is held low before request-to-send (120 us at 100 MHz).
REQ-003 Parameter TIMEOUT_CYCLES, 1_500_000, maximum clk cycles allowed between consecutive device clock falling edges, and before the first one (15 ms).
REQ-004 Parameter FILTER_CYCLES, 8, clk cycles a synchronised PS/2 line must hold a level before that level is accepted.
REQ-005 clk  input  1  onboard clock; one clock domain only.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 tx_data  input  8  command byte to send to the keyboard, e.g. 0xED set-LEDs or 0xFF reset.
REQ-008 tx_valid  input  1  request; a byte is accepted on any clk edge where tx_valid=1 and tx_ready=1.
REQ-009 tx_ready  output  1  high only in IDLE.
REQ-010 ps2_clk_in  input  1  sensed PS/2 clock line, asynchronous.
REQ-011 ps2_data_in  input  1  sensed PS/2 data line, asynchronous.
REQ-012 ps2_clk_drive_low  output  1  1 = pull PS/2 clock low; 0 = release it (open-drain).
REQ-013 ps2_data_drive_low  output  1  1 = pull PS/2 data low; 0 = release it.
REQ-014 busy  output  1  high in every state except IDLE; the receiver ignores the bus while busy=1.
REQ-015 tx_done  output  1  one-cycle pulse when the device acknowledges the byte.
REQ-016 tx_err  output  1  one-cycle pulse when the ack is missing or a timeout occurs.

Function
REQ-017 Each PS/2 line shall pass through a 2-flop synchroniser and a FILTER_CYCLES stability filter before use.
REQ-018 A falling edge is a filtered-clock 1->0 transition; it is flagged one cycle after the filter accepts it.
REQ-019 States: IDLE, INHIBIT, RTS, SHIFT, ACK, RELEASE.
REQ-020 IDLE: on acceptance, latch tx_data, compute odd parity (~^tx_data), clear bit counter and timer, go to INHIBIT.
REQ-021 INHIBIT: ps2_clk_drive_low=1 for INHIBIT_CYCLES cycles, then go to RTS.
REQ-022 RTS: ps2_data_drive_low=1 (start bit) and ps2_clk_drive_low=1 for one cycle, then release the clock and go to SHIFT.
REQ-023 SHIFT: on falling edges 1-8 drive data bit n-1 (LSB first); on edge 9 drive parity; on edge 10 release data (stop bit). Drive value 0 means drive_low=1.
REQ-024 On the 11th falling edge, go to ACK.
REQ-025 ACK: sample filtered data on entry; 0 means the ack is valid, go to RELEASE; 1 means pulse tx_err and go to RELEASE.
REQ-026 RELEASE: wait until the filtered clock and data are both 1, then go to IDLE; tx_done pulses on the same edge, but only if the ack was valid.
REQ-027 The timer shall count clk cycles in RTS, SHIFT and RELEASE, and clear on every falling edge.
REQ-028 If the timer reaches TIMEOUT_CYCLES: release both lines, pulse tx_err, go to IDLE.
REQ-029 tx_valid asserted while busy=1 shall be ignored; tx_data shall not be re-sampled mid-frame.
REQ-030 tx_done and tx_err shall never be high in the same cycle.
REQ-031 Bit counter shall be 4 bits and saturate at 11; it shall not wrap.
REQ-032 Only the drive_low outputs shall touch the bus, and never drive high.

Reset
REQ-033 While rst_n=0: state=IDLE, ps2_clk_drive_low=0, ps2_data_drive_low=0, busy=0, tx_ready=0, tx_done=0, tx_err=0, counters=0, filters preset to 1.
REQ-034 Reset asserted mid-frame shall release both lines immediately (asynchronously), with no pulse on tx_done or tx_err.
REQ-035 tx_ready shall rise on the first clk edge after rst_n deasserts.

Structure
REQ-036 Shared package ps2_pkg: state enum, command constants (CMD_SET_LEDS=8'hED, CMD_RESET=8'hFF, CMD_ENABLE=8'hF4), ACK_BYTE=8'hFA.
REQ-037 One sub-module, ps2_line_filter (synchroniser plus stability filter), instantiated once per line; the receiver reuses it.

Verification
REQ-038 Send 0xED with a device model clocking at 12.5 kHz that acks -> bits 1,0,1,1,0,1,1,1, parity 1, stop; tx_done pulses once.
REQ-039 Send 0x01 -> parity bit 0 on the 9th edge; send 0x00 -> parity bit 1.
REQ-040 Device leaves data high on the 11th edge -> tx_err pulses once, no tx_done, lines released.
REQ-041 Device never clocks after RTS -> tx_err exactly TIMEOUT_CYCLES cycles after RTS entry; back in IDLE.
REQ-042 rst_n pulsed low after the 4th falling edge -> both drive_low outputs 0 within the same cycle; next 0xFF frame completes correctly.
REQ-043 tx_valid held high with 0xAA during a 0xF4 frame -> only 0xF4 on the wire; 0xAA is accepted after tx_ready returns.
